// File: rtl/microseq_pkg.sv
// Shared constants for the microcode sequencer: FSM state codes, HALT opcode, default opcode width.
package microseq_pkg;

  localparam int unsigned OP_WIDTH_DEF = 6;
  localparam logic [5:0]  HALT_OPCODE  = 6'h3F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/microseq_if.sv
// RAM-read and execute-handshake bundle between the sequencer (master) and RAM/execute (slave).
interface microseq_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) ();

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic                  branch_taken;
  logic [ADDR_WIDTH-1:0] branch_target;
  logic                  call;
  logic                  ret;

  modport master (
    output rd_addr, instr, instr_pc, instr_valid,
    input  rd_data, instr_ready, branch_taken, branch_target, call, ret
  );

  modport slave (
    input  rd_addr, instr, instr_pc, instr_valid,
    output rd_data, instr_ready, branch_taken, branch_target, call, ret
  );

endinterface

// File: rtl/microseq_ret_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module microseq_ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    top_q, top_inc, top_dec;
  logic [CW-1:0]    cnt_q;

  assign top_inc  = (top_q == PW'(DEPTH - 1)) ? '0 : top_q + PW'(1);
  assign top_dec  = (top_q == '0) ? PW'(DEPTH - 1) : top_q - PW'(1);
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign pop_data = mem_q[top_dec];

  // top_q points at the next free slot, which is also the oldest entry once full
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (clear) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (push) begin
      mem_q[top_q] <= push_data;
      top_q        <= top_inc;
      if (!full) cnt_q <= cnt_q + CW'(1);
    end else if (pop && !empty) begin
      top_q <= top_dec;
      cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// PC/fetch stage in front of the microcode RAM with valid/ready issue, zero-bubble branches and HALT.
// Define MICROSEQ_CALL_EN to add call/ret through a return stack.
module microcode_sequencer
  import microseq_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SIZE        = 1024,
  parameter int unsigned ADDR_WIDTH  = $clog2(SIZE),
  parameter int unsigned OP_WIDTH    = OP_WIDTH_DEF,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       stack_err,
  microseq_if.master bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(SIZE - 1);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, next_pc, pc_inc;
  logic                  busy_d, done_d, valid_q, valid_d, err_d;
  logic                  accept, is_halt, call_req, ret_req;
  logic                  push, pop, clear, full, empty;
  logic [ADDR_WIDTH-1:0] pop_data;

  assign pc_inc  = (pc_q == LAST_PC) ? '0 : pc_q + ADDR_WIDTH'(1);
  assign accept  = valid_q & bus.instr_ready;
  assign is_halt = (bus.rd_data[DATA_WIDTH-1 -: OP_WIDTH] == OP_WIDTH'(HALT_OPCODE));

`ifdef MICROSEQ_CALL_EN
  assign call_req = bus.call;
  assign ret_req  = bus.ret;

  microseq_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .pop_data  (pop_data),
    .full      (full),
    .empty     (empty)
  );
`else
  assign call_req = 1'b0;
  assign ret_req  = 1'b0;
  assign full     = 1'b0;
  assign empty    = 1'b1;
  assign pop_data = '0;

  logic unused_stack;
  assign unused_stack = ^{push, pop, clear, bus.call, bus.ret, 32'(STACK_DEPTH)};
`endif

  // Next state, next PC and stack control; HALT outranks call, ret and branch
  always_comb begin
    state_d = state_q;
    next_pc = pc_q;
    busy_d  = busy;
    done_d  = 1'b0;
    valid_d = valid_q;
    err_d   = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        next_pc = '0;
        // done still high means HALT was just accepted; a same-cycle start is dropped
        if (start && !done) begin
          busy_d  = 1'b1;
          clear   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        valid_d = 1'b1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          if (is_halt) begin
            next_pc = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end else if (call_req) begin
            push    = 1'b1;
            err_d   = full;
            next_pc = bus.branch_target;
          end else if (ret_req) begin
            if (empty) begin
              err_d   = 1'b1;
              next_pc = pc_inc;
            end else begin
              pop     = 1'b1;
              next_pc = pop_data;
            end
          end else if (bus.branch_taken) begin
            next_pc = bus.branch_target;
          end else begin
            next_pc = pc_inc;
          end
        end
      end
      default: begin
        next_pc = '0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      valid_q   <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= next_pc;
      busy      <= busy_d;
      done      <= done_d;
      valid_q   <= valid_d;
      stack_err <= err_d;
    end
  end

  // RAM answers one cycle later, so the word on rd_data belongs to pc_q
  assign bus.rd_addr     = next_pc;
  assign bus.instr       = bus.rd_data;
  assign bus.instr_pc    = pc_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Self-checking bench for microcode_sequencer: directed programs plus random runs against a reference model.
module tb_microcode_sequencer;

  localparam int unsigned DW   = 32;
  localparam int unsigned SIZE = 1024;
  localparam int unsigned AW   = 10;
  localparam logic [31:0] NOP  = 32'h0000_0000;
  localparam logic [31:0] HALT = 32'hFC00_0000;
`ifdef MICROSEQ_CALL_EN
  localparam bit CALL_EN = 1'b1;
`else
  localparam bit CALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, start, busy, done, stack_err;
  logic [31:0] mem [SIZE];

  microseq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  microcode_sequencer #(
    .DATA_WIDTH  (DW),
    .SIZE        (SIZE),
    .ADDR_WIDTH  (AW),
    .OP_WIDTH    (6),
    .STACK_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stack_err (stack_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Microcode RAM: one-cycle read latency
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int errors = 0;
  int checks = 0;
  int err_seen = 0;

  // Reference model: program-level view of what execute should see
  bit          m_busy, m_valid, m_done, m_err;
  int unsigned m_pc;
  int unsigned m_stack[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_valid = 0; m_done = 0; m_err = 0; m_pc = 0;
    m_stack.delete();
  endtask

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < int'(SIZE); i++) mem[i] = w;
  endtask

  // One clock: check presented outputs, drive inputs, check rd_addr, advance model
  task automatic step(input bit st, input bit rdy, input bit br, input int unsigned tgt,
                      input bit cl, input bit rt);
    int unsigned nxt;
    bit acc, halt, err, chk_addr;
    @(negedge clk);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("instr_valid", bus.instr_valid, m_valid);
    check("stack_err", stack_err, m_err);
    if (stack_err) err_seen++;
    if (m_valid) begin
      check("instr_pc", bus.instr_pc, m_pc);
      check("instr", bus.instr, mem[m_pc]);
    end
    start = st; bus.instr_ready = rdy; bus.branch_taken = br;
    bus.branch_target = AW'(tgt); bus.call = cl; bus.ret = rt;

    acc = m_valid && rdy;
    halt = acc && (mem[m_pc][31:26] == 6'h3F);
    err = 0; chk_addr = 1; nxt = m_pc;
    if (!m_busy) nxt = 0;
    else if (!m_valid || !acc) nxt = m_pc;
    else if (halt) chk_addr = 0;
    else if (CALL_EN && cl) begin
      if (m_stack.size() == 4) begin void'(m_stack.pop_front()); err = 1; end
      m_stack.push_back((m_pc + 1) % SIZE);
      nxt = tgt;
    end else if (CALL_EN && rt) begin
      if (m_stack.size() == 0) begin err = 1; nxt = (m_pc + 1) % SIZE; end
      else nxt = m_stack.pop_back();
    end else if (br) nxt = tgt;
    else nxt = (m_pc + 1) % SIZE;
    #1;
    if (chk_addr) check("rd_addr", bus.rd_addr, nxt);

    if (!m_busy) begin
      if (st && !m_done) begin m_busy = 1; m_pc = 0; m_stack.delete(); end
      m_done = 0;
    end else if (!m_valid) begin
      m_valid = 1;
    end else begin
      m_done = halt;
      if (halt) begin m_busy = 0; m_valid = 0; end
      else m_pc = nxt;
    end
    m_err = err;
  endtask

  // Start a run and drive it until the model expects HALT to be accepted
  task automatic run_to_halt(input int mode, input int budget, input bit hold_start);
    bit br, cl, rt, rdy, st, did;
    int unsigned tgt;
    int stalls, n;
    stalls = 0; did = 0;
    step(1, 1, 0, 0, 0, 0);
    for (n = 0; n < budget; n++) begin
      rdy = 1; br = 0; cl = 0; rt = 0; tgt = 0; st = hold_start;
      case (mode)
        1: if (m_valid && m_pc == 2 && stalls < 3) begin rdy = 0; stalls++; end
        2: if (m_valid && m_pc == 1 && !did) begin br = 1; tgt = 'h3F0; did = 1; end
        3: if (m_valid && m_pc == 1 && !did) begin br = 1; tgt = SIZE - 1; did = 1; end
        4: begin
          if (m_valid && m_pc == 4) begin cl = 1; tgt = 'h100; end
          if (m_valid && m_pc == 'h102) rt = 1;
        end
        5: begin
          if (m_valid && (m_pc == 0 || m_pc == 'h10 || m_pc == 'h20 || m_pc == 'h30 || m_pc == 'h40))
            begin cl = 1; tgt = m_pc + 'h10; end
          if (m_valid && (m_pc == 'h50 || m_pc == 'h41 || m_pc == 'h31 || m_pc == 'h21 || m_pc == 'h11))
            rt = 1;
        end
        6: begin
          rdy = ($urandom_range(0, 3) != 0);
          br  = ($urandom_range(0, 7) == 0);
          tgt = $urandom_range(0, SIZE - 1);
          cl  = ($urandom_range(0, 9) == 0);
          rt  = ($urandom_range(0, 9) == 0);
          st  = $urandom_range(0, 1);
        end
        default: ;
      endcase
      step(st, rdy, br, tgt, cl, rt);
      if (m_done) break;
    end
    check("halt_reached", (n < budget), 1);
  endtask

  initial begin
    reset_n = 0; start = 0;
    bus.instr_ready = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.call = 0; bus.ret = 0;
    fill(NOP);
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    reset_n = 1;
    step(0, 0, 0, 0, 0, 0);

    // Linear run, then start held across done: ignored on done, honoured next cycle
    mem[5] = HALT;
    run_to_halt(0, 40, 1);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    run_to_halt(0, 40, 0);
    step(0, 0, 0, 0, 0, 0);

    // Stall at pc 2
    fill(NOP); mem[6] = HALT;
    run_to_halt(1, 40, 0);
    step(0, 0, 0, 0, 0, 0);

    // Branch with no bubble
    fill(NOP); mem['h3F1] = HALT;
    run_to_halt(2, 40, 0);
    step(0, 0, 0, 0, 0, 0);

    // Wrap from 1023 to 0
    fill(NOP); mem[3] = HALT;
    run_to_halt(3, 40, 0);
    step(0, 0, 0, 0, 0, 0);

    // Call/ret round trip
    fill(NOP); mem[6] = HALT;
    run_to_halt(4, 60, 0);
    step(0, 0, 0, 0, 0, 0);

    // Overflow on 5th call, underflow on ret from empty
    fill(NOP); mem['h12] = HALT;
    err_seen = 0;
    run_to_halt(5, 200, 0);
    step(0, 0, 0, 0, 0, 0);
    check("stack_err_pulses", err_seen, CALL_EN ? 2 : 0);

    // Reset mid-run aborts with outputs at reset values immediately
    fill(NOP); mem[50] = HALT;
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_valid", bus.instr_valid, 0);
    check("midrst_instr_pc", bus.instr_pc, 0);
    check("midrst_rd_addr", bus.rd_addr, 0);
    check("midrst_stack_err", stack_err, 0);
    @(negedge clk);
    check("midrst_no_done", done, 0);
    reset_n = 1;
    model_reset();
    step(0, 0, 0, 0, 0, 0);

    // Random programs with random handshake, branches, calls and starts
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < int'(SIZE); i++) begin
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 9) == 0) w[31:26] = 6'h3F;
        else if (w[31:26] == 6'h3F) w[31:26] = 6'h00;
        mem[i] = w;
      end
      run_to_halt(6, 2000, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
